// File: rtl/pt_frame_sequencer.sv
// Frame sequencer for the projective transform: one pass per captured frame.
// Latches corners, answers pixel requests from the double-buffered memory.
//
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   frame_start        : pulse, new source frame captured
//   corners_valid      : pulse, new corner set on in_*_x / in_*_y
//   pt_enable_in       : transform enable, sampled when a pass starts
//   request_pixel      : transform ready for its next source pixel
//   pt_wr              : transform write strobe (counted into wr_count)
//   mem_rd_req/addr    : single read request, address {bank, offset}
//   mem_rd_valid/data  : read return, latency of one cycle or more
//   frame_flag         : start pulse to the transform
//   corners_flag       : corners-updated pulse to the transform
//   a_x..d_y           : corners applied for the current pass
//   ptflag             : transform enable for the current pass
//   pixel/pixel_flag   : source pixel and its one-cycle valid
//   src_bank           : bank being read
//   busy               : sequencer not idle
//   frame_done         : pulse at the end of a pass
//   overrun            : sticky, frame_start arrived while busy
//   wr_count           : saturating pt_wr count for the current/last pass
module pt_frame_sequencer #(
   parameter int H_PIXELS     = 640,
   parameter int V_PIXELS     = 480,
   parameter int ADDR_W       = 19,
   parameter int DRAIN_CYCLES = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              frame_start,
   input  logic              corners_valid,
   input  logic [9:0]        in_a_x,
   input  logic [9:0]        in_b_x,
   input  logic [9:0]        in_c_x,
   input  logic [9:0]        in_d_x,
   input  logic [8:0]        in_a_y,
   input  logic [8:0]        in_b_y,
   input  logic [8:0]        in_c_y,
   input  logic [8:0]        in_d_y,
   input  logic              pt_enable_in,
   input  logic              request_pixel,
   input  logic              pt_wr,
   output logic              mem_rd_req,
   output logic [ADDR_W:0]   mem_rd_addr,
   input  logic              mem_rd_valid,
   input  logic [17:0]       mem_rd_data,
   output logic              frame_flag,
   output logic              corners_flag,
   output logic [9:0]        a_x,
   output logic [9:0]        b_x,
   output logic [9:0]        c_x,
   output logic [9:0]        d_x,
   output logic [8:0]        a_y,
   output logic [8:0]        b_y,
   output logic [8:0]        c_y,
   output logic [8:0]        d_y,
   output logic              ptflag,
   output logic [17:0]       pixel,
   output logic              pixel_flag,
   output logic              src_bank,
   output logic              busy,
   output logic              frame_done,
   output logic              overrun,
   output logic [18:0]       wr_count
);

   localparam int CNT_W = ADDR_W + 1;
   localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [CNT_W-1:0] NPIX     = CNT_W'(H_PIXELS * V_PIXELS);
   localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_FETCH,
      S_WAIT,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [75:0]       shadow_q, shadow_d;
   logic [75:0]       corners_q, corners_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  cnt_inc;
   logic [DRN_W-1:0]  drn_q, drn_d;
   logic              rd_req_q, rd_req_d;
   logic [ADDR_W:0]   rd_addr_q, rd_addr_d;
   logic              frame_flag_q, frame_flag_d;
   logic              corners_flag_q, corners_flag_d;
   logic              ptflag_q, ptflag_d;
   logic [17:0]       pixel_q, pixel_d;
   logic              pixel_flag_q, pixel_flag_d;
   logic              bank_q, bank_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              overrun_q, overrun_d;
   logic [18:0]       wr_count_q, wr_count_d;

   assign cnt_inc = cnt_q + CNT_W'(1);

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      drn_d          = drn_q;
      rd_req_d       = 1'b0;
      rd_addr_d      = rd_addr_q;
      frame_flag_d   = 1'b0;
      corners_flag_d = 1'b0;
      corners_d      = corners_q;
      ptflag_d       = ptflag_q;
      pixel_d        = pixel_q;
      pixel_flag_d   = 1'b0;
      bank_d         = bank_q;
      done_d         = 1'b0;

      // Shadow follows corners_valid in every state, so a set arriving
      // in the START cycle is the one applied.
      shadow_d = shadow_q;
      if (corners_valid) begin
         shadow_d = {in_a_x, in_b_x, in_c_x, in_d_x,
                     in_a_y, in_b_y, in_c_y, in_d_y};
      end

      overrun_d = overrun_q | (frame_start & (state_q != S_IDLE));

      wr_count_d = wr_count_q;
      if (pt_wr && (state_q != S_IDLE) && (wr_count_q != '1)) begin
         wr_count_d = wr_count_q + 19'd1;
      end

      unique case (state_q)
         S_IDLE: begin
            if (frame_start) state_d = S_START;
         end
         S_START: begin
            frame_flag_d   = 1'b1;
            corners_flag_d = 1'b1;
            corners_d      = shadow_d;
            ptflag_d       = pt_enable_in;
            cnt_d          = '0;
            wr_count_d     = '0;
            state_d        = S_FETCH;
         end
         S_FETCH: begin
            if (request_pixel && (cnt_q < NPIX)) begin
               rd_req_d  = 1'b1;
               rd_addr_d = {bank_q, cnt_q[ADDR_W-1:0]};
               state_d   = S_WAIT;
            end
         end
         S_WAIT: begin
            if (mem_rd_valid) begin
               pixel_d      = mem_rd_data;
               pixel_flag_d = 1'b1;
               cnt_d        = cnt_inc;
               drn_d        = '0;
               state_d      = (cnt_inc == NPIX) ? S_DRAIN : S_FETCH;
            end
         end
         S_DRAIN: begin
            if (drn_q == DRN_LAST) begin
               done_d  = 1'b1;
               bank_d  = ~bank_q;
               state_d = S_DONE;
            end else begin
               drn_d = drn_q + DRN_W'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= S_IDLE;
         shadow_q       <= '0;
         corners_q      <= '0;
         cnt_q          <= '0;
         drn_q          <= '0;
         rd_req_q       <= 1'b0;
         rd_addr_q      <= '0;
         frame_flag_q   <= 1'b0;
         corners_flag_q <= 1'b0;
         ptflag_q       <= 1'b0;
         pixel_q        <= '0;
         pixel_flag_q   <= 1'b0;
         bank_q         <= 1'b0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         overrun_q      <= 1'b0;
         wr_count_q     <= '0;
      end else begin
         state_q        <= state_d;
         shadow_q       <= shadow_d;
         corners_q      <= corners_d;
         cnt_q          <= cnt_d;
         drn_q          <= drn_d;
         rd_req_q       <= rd_req_d;
         rd_addr_q      <= rd_addr_d;
         frame_flag_q   <= frame_flag_d;
         corners_flag_q <= corners_flag_d;
         ptflag_q       <= ptflag_d;
         pixel_q        <= pixel_d;
         pixel_flag_q   <= pixel_flag_d;
         bank_q         <= bank_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         overrun_q      <= overrun_d;
         wr_count_q     <= wr_count_d;
      end
   end

   assign mem_rd_req   = rd_req_q;
   assign mem_rd_addr  = rd_addr_q;
   assign frame_flag   = frame_flag_q;
   assign corners_flag = corners_flag_q;
   assign {a_x, b_x, c_x, d_x, a_y, b_y, c_y, d_y} = corners_q;
   assign ptflag       = ptflag_q;
   assign pixel        = pixel_q;
   assign pixel_flag   = pixel_flag_q;
   assign src_bank     = bank_q;
   assign busy         = busy_q;
   assign frame_done   = done_q;
   assign overrun      = overrun_q;
   assign wr_count     = wr_count_q;

endmodule

// File: tb/tb_pt_frame_sequencer.sv
// Self-checking bench for pt_frame_sequencer on a 4x2 frame.
// Random backpressure and memory latency against a pass-level model.
module tb_pt_frame_sequencer;

   localparam int H  = 4;
   localparam int V  = 2;
   localparam int AW = 3;
   localparam int DR = 3;
   localparam int N  = H * V;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset, frame_start, corners_valid;
   logic [9:0]    in_a_x, in_b_x, in_c_x, in_d_x;
   logic [8:0]    in_a_y, in_b_y, in_c_y, in_d_y;
   logic          pt_enable_in, request_pixel, pt_wr;
   logic          mem_rd_req, mem_rd_valid;
   logic [AW:0]   mem_rd_addr;
   logic [17:0]   mem_rd_data;
   logic          frame_flag, corners_flag, ptflag, pixel_flag;
   logic [9:0]    a_x, b_x, c_x, d_x;
   logic [8:0]    a_y, b_y, c_y, d_y;
   logic [17:0]   pixel;
   logic          src_bank, busy, frame_done, overrun;
   logic [18:0]   wr_count;

   pt_frame_sequencer #(
      .H_PIXELS(H), .V_PIXELS(V), .ADDR_W(AW), .DRAIN_CYCLES(DR)
   ) dut (
      .clk(clk), .reset(reset), .frame_start(frame_start),
      .corners_valid(corners_valid),
      .in_a_x(in_a_x), .in_b_x(in_b_x), .in_c_x(in_c_x), .in_d_x(in_d_x),
      .in_a_y(in_a_y), .in_b_y(in_b_y), .in_c_y(in_c_y), .in_d_y(in_d_y),
      .pt_enable_in(pt_enable_in), .request_pixel(request_pixel),
      .pt_wr(pt_wr), .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr),
      .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
      .frame_flag(frame_flag), .corners_flag(corners_flag),
      .a_x(a_x), .b_x(b_x), .c_x(c_x), .d_x(d_x),
      .a_y(a_y), .b_y(b_y), .c_y(c_y), .d_y(d_y),
      .ptflag(ptflag), .pixel(pixel), .pixel_flag(pixel_flag),
      .src_bank(src_bank), .busy(busy), .frame_done(frame_done),
      .overrun(overrun), .wr_count(wr_count)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input longint got,
                      input longint exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // memory: one pending read, returns addr+100 after lat cycles
   int          lat_min = 1;
   int          lat_max = 1;
   bit          pend = 0;
   int          lat_cnt = 0;
   logic [AW:0] pend_addr;

   initial begin
      mem_rd_valid = 1'b0;
      mem_rd_data  = '0;
      forever begin
         @(negedge clk);
         if (mem_rd_req) begin
            chk("one_outstanding", pend, 0);
            pend      = 1;
            pend_addr = mem_rd_addr;
            lat_cnt   = $urandom_range(lat_max, lat_min);
         end
         @(posedge clk);
         #1;
         mem_rd_valid = 1'b0;
         if (pend) begin
            lat_cnt--;
            if (lat_cnt == 0) begin
               mem_rd_valid = 1'b1;
               mem_rd_data  = 18'(pend_addr) + 18'd100;
               pend         = 0;
            end
         end
      end
   end

   bit rq_rand  = 0;
   bit rq_level = 0;

   initial begin
      request_pixel = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         request_pixel = rq_rand ? 1'($urandom_range(0, 1)) : rq_level;
      end
   end

   // monitor
   int          cyc = 0;
   bit          rp_edge = 0;
   logic [AW:0] got_addr[$];
   logic [17:0] got_pix[$];
   int          n_ff, n_cf, n_fd;
   int          first_req, first_pix, last_pix, done_cyc;
   logic [4:0]  pl_prev = '0;
   logic [4:0]  pl_cur;

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         rp_edge = request_pixel;
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (mem_rd_req === 1'b1) begin
            chk("req_needs_rq", rp_edge, 1);
            got_addr.push_back(mem_rd_addr);
            if (first_req < 0) first_req = cyc;
         end
         if (pixel_flag === 1'b1) begin
            got_pix.push_back(pixel);
            if (first_pix < 0) first_pix = cyc;
            last_pix = cyc;
         end
         if (frame_flag === 1'b1) n_ff++;
         if (corners_flag === 1'b1) n_cf++;
         if (frame_done === 1'b1) begin
            n_fd++;
            done_cyc = cyc;
         end
         pl_cur = {frame_flag, corners_flag, mem_rd_req,
                   pixel_flag, frame_done};
         if (pl_cur != '0) chk("pulse_width", pl_cur & pl_prev, 0);
         pl_prev = pl_cur;
      end
   end

   task automatic clear();
      got_addr.delete();
      got_pix.delete();
      n_ff = 0; n_cf = 0; n_fd = 0;
      first_req = -1; first_pix = -1; last_pix = -1; done_cyc = -1;
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_start();
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
   endtask

   task automatic wait_done();
      int k = 0;
      while (n_fd == 0 && k < 600) begin
         step();
         k++;
      end
      chk("done_seen", n_fd, 1);
   endtask

   task automatic check_pass(input int bank, input string tag);
      int na, np;
      longint ea;
      na = got_addr.size();
      np = got_pix.size();
      chk({tag, "_nreads"}, na, N);
      chk({tag, "_npix"}, np, N);
      for (int i = 0; i < N; i++) begin
         ea = bank * (1 << AW) + i;
         if (i < na) chk({tag, "_addr"}, got_addr[i], ea);
         if (i < np) chk({tag, "_pix"}, got_pix[i], ea + 100);
      end
      chk({tag, "_frame_flags"}, n_ff, 1);
      chk({tag, "_corner_flags"}, n_cf, 1);
      chk({tag, "_drain_gap"}, done_cyc - last_pix, DR);
      chk({tag, "_bank_after"}, src_bank, bank ^ 1);
   endtask

   initial begin
      int k, npre;
      reset = 1'b1; frame_start = 1'b0; corners_valid = 1'b0;
      pt_enable_in = 1'b0; pt_wr = 1'b0;
      in_a_x = '0; in_b_x = '0; in_c_x = '0; in_d_x = '0;
      in_a_y = '0; in_b_y = '0; in_c_y = '0; in_d_y = '0;
      clear();
      step(3);
      chk("rst_busy", busy, 0);
      chk("rst_bank", src_bank, 0);
      chk("rst_ff", frame_flag, 0);
      chk("rst_req", mem_rd_req, 0);
      chk("rst_pf", pixel_flag, 0);
      chk("rst_done", frame_done, 0);
      chk("rst_ovr", overrun, 0);
      chk("rst_wr", wr_count, 0);
      chk("rst_ax", a_x, 0);
      chk("rst_pt", ptflag, 0);
      chk("rst_pix", pixel, 0);
      reset = 1'b0;
      step();

      // pass 1: fixed latency, request held high
      in_a_x = 11; in_b_x = 22; in_c_x = 33; in_d_x = 44;
      in_a_y = 55; in_b_y = 66; in_c_y = 77; in_d_y = 88;
      corners_valid = 1'b1;
      step();
      corners_valid = 1'b0;
      pt_enable_in = 1'b1;
      rq_level = 1;
      step();
      clear();
      pulse_start();
      fork
         wait_done();
         begin
            step(4);
            repeat (5) begin
               pt_wr = 1'b1;
               step();
               pt_wr = 1'b0;
               step();
            end
            in_a_x = 300; in_d_y = 200;
            corners_valid = 1'b1;
            step();
            corners_valid = 1'b0;
            step();
            chk("ax_hold", a_x, 11);
            chk("dy_hold", d_y, 88);
         end
      join
      check_pass(0, "p1");
      chk("p1_latency", first_pix - first_req, 2);
      chk("p1_wr_count", wr_count, 5);
      chk("p1_ax", a_x, 11);
      chk("p1_cy", c_y, 77);
      chk("p1_ptflag", ptflag, 1);
      step(5);
      chk("wr_hold", wr_count, 5);
      chk("idle_busy", busy, 0);

      // pass 2: random backpressure and latency, bank 1
      rq_rand = 1; lat_min = 1; lat_max = 5;
      pt_enable_in = 1'b0;
      clear();
      pulse_start();
      step();
      chk("wr_cleared", wr_count, 0);
      chk("p2_ax", a_x, 300);
      chk("p2_dy", d_y, 200);
      chk("p2_bx", b_x, 22);
      chk("p2_ptflag", ptflag, 0);
      wait_done();
      check_pass(1, "p2");

      // pass 3: corners coincident with START, frame_start during WAIT
      in_a_x = 777; in_d_y = 333;
      clear();
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      corners_valid = 1'b1;
      step();
      corners_valid = 1'b0;
      chk("p3_ax", a_x, 777);
      chk("p3_dy", d_y, 333);
      fork
         wait_done();
         begin
            k = 0;
            while (got_addr.size() == 0 && k < 200) begin
               step();
               k++;
            end
            frame_start = 1'b1;
            step();
            frame_start = 1'b0;
         end
      join
      check_pass(0, "p3");
      chk("ovr_set", overrun, 1);
      step(6);
      chk("no_restart", busy, 0);
      chk("ovr_sticky", overrun, 1);
      chk("no_extra_ff", n_ff, 1);

      // pass 4: reset after the third pixel, read in flight
      rq_rand = 0; rq_level = 1; lat_min = 5; lat_max = 5;
      clear();
      pulse_start();
      k = 0;
      while (got_pix.size() < 3 && k < 200) begin
         step();
         k++;
      end
      chk("p4_three_pix", got_pix.size(), 3);
      reset = 1'b1;
      step();
      chk("mr_busy", busy, 0);
      chk("mr_bank", src_bank, 0);
      chk("mr_ovr", overrun, 0);
      chk("mr_ax", a_x, 0);
      chk("mr_pix", pixel, 0);
      chk("mr_wr", wr_count, 0);
      chk("mr_pt", ptflag, 0);
      chk("mr_addr", mem_rd_addr, 0);
      reset = 1'b0;
      npre = got_pix.size();
      step(10);
      chk("late_valid_ignored", got_pix.size(), npre);

      // pass 5: fresh start after reset reads bank 0 from offset 0
      rq_rand = 1; lat_min = 1; lat_max = 3;
      clear();
      pulse_start();
      wait_done();
      check_pass(0, "p5");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
